iir_seq_ctrl: RTL
=================

// Module: iir_seq_ctrl
// PURPOSE
//  Sequencer for a 4th-order direct-form-I IIR filter sharing ONE signed multiplier-accumulator.
//  Streams samples from sample memory, runs 9 MACs per sample, writes result to output memory.
//  Sits between the sample/result memories and the testbench/host start/done handshake.
// PARAMETERS
//  DATA_W  16  sample and result width, signed two's complement
//  COEF_W  20  coefficient width, signed Q4.16
//  ADDR_W  20  memory address width
//  FRAC    16  fractional bits removed from accumulator
//  ACC_W   40  accumulator width (36-bit product + 4 guard bits)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  start      in   1       one-cycle pulse: begin a run at address 0
//  DIn        in   DATA_W  sample read data, valid the cycle after load=1
//  data_done  in   1       high when the current RAddr is the last sample
//  load       out  1       sample read strobe
//  RAddr      out  ADDR_W  sample read address
//  WEN        out  1       result write strobe, one cycle per sample
//  WAddr      out  ADDR_W  result write address (= RAddr of the same sample)
//  Yn         out  DATA_W  result data, valid while WEN=1
//  busy       out  1       run in progress
//  Finish     out  1       run complete, held until start or rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x[0..4], y[1..4] history and acc cleared.
//  FSM: IDLE -start-> FETCH -> CAPT -> MAC(k=0..8) -> WRITE -> FETCH or DONE; DONE -start-> FETCH.
//  FETCH: load=1, RAddr stable. CAPT: shift x history, x[0]<=DIn; acc<=0; k<=0.
//  MAC: k=0..4: acc += A[k]*x[k]; k=5..8: acc -= B[k-4]*y[k-4]; one product/cycle.
//  WRITE: WEN=1, WAddr=RAddr, Yn=result; y history shifts with result.
//  WRITE exit: data_done=1 -> DONE; otherwise RAddr+1, -> FETCH.
//  Throughput: 12 cycles/sample. First WEN in the 12th cycle after the start pulse.
//  Result = acc[FRAC+DATA_W-1:FRAC] (arithmetic >>> FRAC); product sign-extended to ACC_W.
//  Finish rises the cycle after the final WRITE; busy=0 in IDLE/DONE, 1 otherwise.
//  start in FETCH..WRITE: ignored. start in DONE: history cleared, RAddr=0, Finish=0, -> FETCH.
//  RAddr at 2^ADDR_W-1 without data_done: wraps to 0, run continues.
//  rst mid-run: immediate abort to reset state; no further WEN.
// CONFIGURATION
//  IIR_SAT_EN defined: result clamps to 16'h7FFF / 16'h8000 when acc[ACC_W-1:FRAC+DATA_W-1] is not all-equal.
//  IIR_SAT_EN undefined: plain truncation (wraps); the clamp logic is absent.
//  The y history always stores the same value driven on Yn.
// STRUCTURE
//  Package iir_pkg: FSM state enum, A[0..4] and B[1..4] coefficient constants (Q4.16), width localparams.
//  Sub-module iir_coef_rom: k(4b) -> signed COEF_W coefficient plus subtract flag, combinational.
//  Top: FSM, address counter, history shift registers, shared MAC, output rounding/clamp.
// TESTING
//  Zero input, 8 samples of 16'h0000, data_done on addr 7 -> eight WEN pulses, Yn=0, WAddr 0..7, then Finish=1.
//  Impulse DIn[0]=16'h7FFF, others 0; A[0]=20'h004F9 -> Yn[0]=636 (16'h027C); later taps match golden model.
//  Timing: start at cycle 0 -> load at cycle 1, first WEN at cycle 12, next WEN at cycle 24.
//  Sustained 16'h8000 with IIR_SAT_EN -> every Yn within [16'h8000,16'h7FFF] with no sign flip; without it -> matches wrapped model.
//  rst asserted during MAC of sample 3 -> all outputs 0 next edge; restart reproduces sample 0 result.
//  start pulsed while busy -> ignored; start in DONE -> new run from RAddr=0 with cleared history.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR sequencer: widths, FSM state codes and the
// Q4.16 filter coefficients. Optional result saturation is enabled by
// defining IIR_SAT_EN (handled in iir_seq_ctrl).
package iir_pkg;

  localparam int DATA_W = 16;              // sample / result width
  localparam int COEF_W = 20;              // coefficient width, Q4.16
  localparam int ADDR_W = 20;              // memory address width
  localparam int FRAC   = 16;              // fractional bits dropped from acc
  localparam int ACC_W  = 40;              // product width plus 4 guard bits
  localparam int PROD_W = COEF_W + DATA_W; // full signed product width
  localparam int K_W    = 4;               // MAC step counter width

  // Last MAC step: 5 feed-forward taps followed by 4 feedback taps.
  localparam logic [K_W-1:0] K_LAST = 4'd8;

  // FSM state codes, kept as plain constants for the legacy encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_CAPT  = 3'd2;
  localparam state_t ST_MAC   = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Feed-forward coefficients A[0..4] (added).
  localparam logic signed [COEF_W-1:0] COEF_A0 = 20'h004F9; //  0.01942
  localparam logic signed [COEF_W-1:0] COEF_A1 = 20'h10000; //  1.0
  localparam logic signed [COEF_W-1:0] COEF_A2 = 20'h08000; //  0.5
  localparam logic signed [COEF_W-1:0] COEF_A3 = 20'h10000; //  1.0
  localparam logic signed [COEF_W-1:0] COEF_A4 = 20'h004F9; //  0.01942

  // Feedback coefficients B[1..4] (subtracted).
  localparam logic signed [COEF_W-1:0] COEF_B1 = 20'hF8000; // -0.5
  localparam logic signed [COEF_W-1:0] COEF_B2 = 20'h04000; //  0.25
  localparam logic signed [COEF_W-1:0] COEF_B3 = 20'hFE000; // -0.125
  localparam logic signed [COEF_W-1:0] COEF_B4 = 20'h01000; //  0.0625

endpackage

// File: rtl/iir_coef_rom.sv
// Coefficient lookup for the shared MAC: step k selects the coefficient and
// whether its product is added (A taps, k=0..4) or subtracted (B taps, k=5..8).
module iir_coef_rom
  import iir_pkg::*;
(
  input  logic [K_W-1:0]           k_i,
  output logic signed [COEF_W-1:0] coef_o,
  output logic                     sub_o
);

  // Pure table lookup indexed by MAC step.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    coef_o = '0;
    sub_o  = 1'b0;
    case (k_i)
      4'd0: coef_o = COEF_A0;
      4'd1: coef_o = COEF_A1;
      4'd2: coef_o = COEF_A2;
      4'd3: coef_o = COEF_A3;
      4'd4: coef_o = COEF_A4;
      4'd5: begin coef_o = COEF_B1; sub_o = 1'b1; end
      4'd6: begin coef_o = COEF_B2; sub_o = 1'b1; end
      4'd7: begin coef_o = COEF_B3; sub_o = 1'b1; end
      4'd8: begin coef_o = COEF_B4; sub_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/iir_seq_ctrl.sv
// Sequencer for a 4th-order direct-form-I IIR filter built around one shared
// signed multiplier-accumulator. Each sample takes 12 cycles:
// FETCH, CAPT, 9 x MAC, WRITE. Defining IIR_SAT_EN clamps the result to the
// 16-bit signed range instead of letting it wrap.
module iir_seq_ctrl
  import iir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] DIn,
  input  logic              data_done,
  output logic              load,
  output logic [ADDR_W-1:0] RAddr,
  output logic              WEN,
  output logic [ADDR_W-1:0] WAddr,
  output logic [DATA_W-1:0] Yn,
  output logic              busy,
  output logic              Finish
);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q;
  logic [K_W-1:0]            k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  x_q [0:4];
  logic signed [DATA_W-1:0]  y_q [1:4];

  logic signed [COEF_W-1:0]  coef;
  logic                      coef_sub;
  logic signed [DATA_W-1:0]  mac_opnd;
  logic signed [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]          prod_ext;
  logic [DATA_W-1:0]         result;
  logic                      start_run;

  // A run may only be (re)started from IDLE or DONE; start is ignored mid-run.
  assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  iir_coef_rom u_coef_rom (
    .k_i    (k_q),
    .coef_o (coef),
    .sub_o  (coef_sub)
  );

  // Next-state logic for the per-sample sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_CAPT;
      ST_CAPT:          state_d = ST_MAC;
      ST_MAC:           if (k_q == K_LAST) state_d = ST_WRITE;
      ST_WRITE:         state_d = data_done ? ST_DONE : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Sample address: cleared on a new run, advanced after each non-final write;
  // the natural ADDR_W rollover gives the wrap from all-ones to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     addr_q <= '0;
    else if (start_run)                          addr_q <= '0;
    else if ((state_q == ST_WRITE) && !data_done) addr_q <= addr_q + ADDR_W'(1);
  end

  // Input and output history shift registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the history is only nine words and must start from zero on every
    // run, so it is reset like ordinary flops rather than treated as a RAM.
    if (rst || start_run) begin
      for (int i = 0; i <= 4; i++) x_q[i] <= '0;
      for (int i = 1; i <= 4; i++) y_q[i] <= '0;
    end else if (state_q == ST_CAPT) begin
      x_q[4] <= x_q[3];
      x_q[3] <= x_q[2];
      x_q[2] <= x_q[1];
      x_q[1] <= x_q[0];
      x_q[0] <= DIn;
    end else if (state_q == ST_WRITE) begin
      y_q[4] <= y_q[3];
      y_q[3] <= y_q[2];
      y_q[2] <= y_q[1];
      y_q[1] <= result;
    end
  end

  // Operand for the current MAC step: x[k] for k=0..4, y[k-4] for k=5..8.
  always_comb begin
    mac_opnd = '0;
    case (k_q)
      4'd0: mac_opnd = x_q[0];
      4'd1: mac_opnd = x_q[1];
      4'd2: mac_opnd = x_q[2];
      4'd3: mac_opnd = x_q[3];
      4'd4: mac_opnd = x_q[4];
      4'd5: mac_opnd = y_q[1];
      4'd6: mac_opnd = y_q[2];
      4'd7: mac_opnd = y_q[3];
      4'd8: mac_opnd = y_q[4];
      default: ;
    endcase
  end

  // One signed product per cycle, sign-extended to accumulator width.
  assign prod     = coef * mac_opnd;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Shared accumulator and its step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || start_run) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == ST_CAPT) begin
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == ST_MAC) begin
      acc_q <= coef_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
      k_q   <= k_q + K_W'(1);
    end
  end

  // Drop the fractional bits; optionally clamp when the integer part overflows.
  always_comb begin
    result = acc_q[FRAC+DATA_W-1:FRAC];
`ifdef IIR_SAT_EN
    if (!((&acc_q[ACC_W-1:FRAC+DATA_W-1]) || !(|acc_q[ACC_W-1:FRAC+DATA_W-1])))
      result = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
`endif
  end

  assign load   = (state_q == ST_FETCH);
  assign WEN    = (state_q == ST_WRITE);
  assign RAddr  = addr_q;
  assign WAddr  = WEN ? addr_q : '0;
  assign Yn     = WEN ? result : '0;
  assign busy   = !((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign Finish = (state_q == ST_DONE);

endmodule
